// File: rtl/msft_apb_initiator.sv
// APB initiator: accepts one command at a time, runs the APB SETUP/ACCESS
// phases and holds the response. Optional ACCESS timeout: define APB_INIT_TIMEOUT_EN.

module msft_apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic        cmd_write_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic        pwrite_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        psuberr_i,
    output logic        busy_o,
    output logic        timeout_o
);
    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready_o high
    // SETUP  | APB setup phase (psel only), always one cycle
    // ACCESS | APB access phase, waiting for pready_i (or timeout)
    // RESP   | response held until rsp_ready_i

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
    logic [31:0] paddr_d, pwdata_d, rsp_rdata_d;
    logic        timeout_fire;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef APB_INIT_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_q;

    // Fires on the TIMEOUT_CYCLES-th wait cycle; a pready_i on that cycle wins.
    assign timeout_fire = (state_q == ACCESS) && !pready_i &&
                          (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (state_q == IDLE && cmd_valid_i)
                wait_cnt <= '0;
            else if (state_q == ACCESS && !pready_i)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_o;
        penable_d   = penable_o;
        paddr_d     = paddr_o;
        pwdata_d    = pwdata_o;
        pwrite_d    = pwrite_o;
        rsp_valid_d = rsp_valid_o;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d   = SETUP;
                    paddr_d   = cmd_addr_i;
                    pwdata_d  = cmd_wdata_i;
                    pwrite_d  = cmd_write_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_o ? 32'h0 : prdata_i;
                    rsp_err_d   = psuberr_i;
                end else if (timeout_fire) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            paddr_o     <= paddr_d;
            pwdata_o    <= pwdata_d;
            pwrite_o    <= pwrite_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule
